unified_mem_arbiter: RTL and testbench

Arbitrates a single-ported, fixed-latency unified memory between two requesters: instruction fetch (IF) and the pipeline's memory stage (DM). It sequences each access with an issue/wait/respond state machine and gives DM priority, with a starvation limit that protects IF. It produces the stall signals that feed hazard detection, which holds the fetch stage or the memory stage while its access is outstanding.

---
 rtl/unified_mem_arbiter_if.sv | 47 ++++
 rtl/unified_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the requester handshakes (instruction fetch and data memory), the
// memory-side access bus and the hazard stall lines of the unified memory
// arbiter.
//   IF side  : if_req, if_addr -> arbiter; if_rdata, if_valid <- arbiter
//   DM side  : dm_req, dm_we, dm_addr, dm_wdata -> arbiter;
//              dm_rdata, dm_valid <- arbiter
//   Memory   : mem_en, mem_we, mem_addr, mem_wdata <- arbiter;
//              mem_rdata -> arbiter
//   Hazards  : stall_fetch, stall_mem <- arbiter
// Modport master is the arbiter's view; slave is the requester/memory view.
// ---------------------------------------------------------------------------
interface unified_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_fetch;
    logic        stall_mem;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid,
               mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_mem
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
               mem_en, mem_we, mem_addr, mem_wdata, stall_fetch, stall_mem
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// (IF) and the data memory stage (DM). Each access runs IDLE -> ISSUE ->
// WAIT -> RESP. DM has priority unless it has been granted STARVE_LIMIT
// times in a row while IF was waiting, in which case IF is forced through.
// Ports:
//   clock   : rising-edge system clock
//   reset_n : synchronous active-low reset
//   bus     : unified_mem_arbiter_if.master (requesters, memory, stalls)
// Parameters:
//   MEM_LATENCY  : cycles from mem_en to valid mem_rdata (>= 1)
//   STARVE_LIMIT : consecutive DM grants tolerated while IF waits
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    unified_mem_arbiter_if.master        bus
);
    localparam int CntW    = $clog2(MEM_LATENCY + 1);
    localparam int StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0]    LatLoad   = CntW'(MEM_LATENCY);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } stateT;

    stateT               stateR;
    stateT               stateNextS;
    logic                grantDmS;
    logic                grantIfS;
    logic                waitDoneS;

    logic [CntW-1:0]     waitCntR;
    logic [StarveW-1:0]  starveR;
    logic                ownerDmR;   // 1 = access in flight belongs to DM
    logic                weLatchR;   // write flag of the access in flight
    logic                memEnR;
    logic                memWeR;
    logic [31:0]         memAddrR;   // doubles as the latched access address
    logic [31:0]         memWdataR;  // doubles as the latched write data
    logic [31:0]         ifRdataR;
    logic [31:0]         dmRdataR;
    logic                ifValidR;
    logic                dmValidR;

    // Next-state logic and grant decision; requests only matter in IDLE.
    always_comb begin
        stateNextS = stateR;
        grantDmS   = 1'b0;
        grantIfS   = 1'b0;
        waitDoneS  = 1'b0;
        case (stateR)
            IDLE: begin
                if (bus.dm_req && (!bus.if_req || (starveR < StarveMax))) begin
                    grantDmS   = 1'b1;
                    stateNextS = ISSUE;
                end else if (bus.if_req) begin
                    grantIfS   = 1'b1;
                    stateNextS = ISSUE;
                end else begin
                    stateNextS = IDLE;
                end
            end
            ISSUE: stateNextS = WAIT;
            WAIT: begin
                // Count value 1 marks the cycle in which mem_rdata is valid.
                if (waitCntR == CntW'(1)) begin
                    waitDoneS  = 1'b1;
                    stateNextS = RESP;
                end else begin
                    stateNextS = WAIT;
                end
            end
            RESP:    stateNextS = IDLE;
            default: stateNextS = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Access datapath: latches, memory strobes, read capture and valid pulses.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ownerDmR  <= 1'b0;
            weLatchR  <= 1'b0;
            memEnR    <= 1'b0;
            memWeR    <= 1'b0;
            memAddrR  <= 32'h0000_0000;
            memWdataR <= 32'h0000_0000;
            ifRdataR  <= 32'h0000_0000;
            dmRdataR  <= 32'h0000_0000;
            ifValidR  <= 1'b0;
            dmValidR  <= 1'b0;
            waitCntR  <= '0;
        end else begin
            // Strobes are set on the grant edge so they are high exactly in ISSUE.
            memEnR   <= grantDmS | grantIfS;
            memWeR   <= grantDmS & bus.dm_we;
            ifValidR <= waitDoneS & ~ownerDmR;
            dmValidR <= waitDoneS & ownerDmR;

            if (grantDmS) begin
                ownerDmR  <= 1'b1;
                weLatchR  <= bus.dm_we;
                memAddrR  <= bus.dm_addr;
                memWdataR <= bus.dm_wdata;
            end else if (grantIfS) begin
                ownerDmR  <= 1'b0;
                weLatchR  <= 1'b0;
                memAddrR  <= bus.if_addr;
            end

            if (stateR == ISSUE) begin
                waitCntR <= LatLoad;
            end else if ((stateR == WAIT) && (waitCntR != '0)) begin
                waitCntR <= waitCntR - CntW'(1);
            end

            if (waitDoneS) begin
                if (!ownerDmR) begin
                    ifRdataR <= bus.mem_rdata;
                end else if (!weLatchR) begin
                    dmRdataR <= bus.mem_rdata;
                end
            end
        end
    end

    // Starvation counter: counts DM grants that overtook a waiting IF.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            starveR <= '0;
        end else if ((stateR == IDLE) && !bus.if_req) begin
            starveR <= '0;
        end else if (grantIfS) begin
            starveR <= '0;
        end else if (grantDmS && (starveR < StarveMax)) begin
            starveR <= starveR + StarveW'(1);
        end
    end

    assign bus.mem_en      = memEnR;
    assign bus.mem_we      = memWeR;
    assign bus.mem_addr    = memAddrR;
    assign bus.mem_wdata   = memWdataR;
    assign bus.if_rdata    = ifRdataR;
    assign bus.dm_rdata    = dmRdataR;
    assign bus.if_valid    = ifValidR;
    assign bus.dm_valid    = dmValidR;
    assign bus.stall_fetch = bus.if_req & ~ifValidR;
    assign bus.stall_mem   = bus.dm_req & ~dmValidR;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
// Directed self-checking bench for unified_mem_arbiter with MEM_LATENCY=2 and
// STARVE_LIMIT=4. A small memory model returns address-dependent data exactly
// MEM_LATENCY cycles after each mem_en and junk in every other cycle.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;
    localparam int MemLat = 2;

    logic clock;
    logic reset_n;
    int   numChecks = 0;
    int   numFails  = 0;

    int          cycleNo    = 0;
    int          issueCycle = -100;
    logic [31:0] issueAddr  = 32'h0000_0000;

    logic [31:0] grants   [6];
    logic [31:0] expGrant [6];
    int          nGrants;

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(
        .MEM_LATENCY  (MemLat),
        .STARVE_LIMIT (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        case (addr)
            32'h0000_0040: memData = 32'h8C08_0004;
            32'h0000_0200: memData = 32'h1234_5678;
            32'h0000_0000: memData = 32'h2002_0001;
            default:       memData = addr ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory model: remember when and where each access was issued.
    always @(posedge clock) begin
        cycleNo <= cycleNo + 1;
        if (bus.mem_en === 1'b1) begin
            issueCycle <= cycleNo;
            issueAddr  <= bus.mem_addr;
        end
    end

    assign bus.mem_rdata = (cycleNo == issueCycle + MemLat) ? memData(issueAddr)
                                                            : 32'h5A5A_5A5A;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] b(input logic v);
        b = {31'b0, v};
    endfunction

    initial begin
        reset_n      = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h0;
        bus.dm_wdata = 32'h0;
        expGrant = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000, 32'h2000};
        for (int k = 0; k < 6; k++) grants[k] = 32'h0;

        // Reset state
        step(); step(); #1;
        checkVal("rst_mem_en",   b(bus.mem_en),   32'h0);
        checkVal("rst_mem_we",   b(bus.mem_we),   32'h0);
        checkVal("rst_mem_addr", bus.mem_addr,    32'h0);
        checkVal("rst_if_valid", b(bus.if_valid), 32'h0);
        checkVal("rst_dm_valid", b(bus.dm_valid), 32'h0);
        checkVal("rst_if_rdata", bus.if_rdata,    32'h0);
        reset_n = 1'b1;
        step();

        // IF only, fetch at 0x40
        step(); bus.if_req = 1'b1; bus.if_addr = 32'h40; #1;
        checkVal("if_c0_stall", b(bus.stall_fetch), 32'h1);
        checkVal("if_c0_mem_en", b(bus.mem_en), 32'h0);
        step(); #1;
        checkVal("if_c1_mem_en", b(bus.mem_en), 32'h1);
        checkVal("if_c1_mem_we", b(bus.mem_we), 32'h0);
        checkVal("if_c1_addr", bus.mem_addr, 32'h40);
        checkVal("if_c1_stall", b(bus.stall_fetch), 32'h1);
        step(); #1;
        checkVal("if_c2_mem_en", b(bus.mem_en), 32'h0);
        checkVal("if_c2_stall", b(bus.stall_fetch), 32'h1);
        step(); #1;
        checkVal("if_c3_valid", b(bus.if_valid), 32'h0);
        checkVal("if_c3_stall", b(bus.stall_fetch), 32'h1);
        step(); #1;
        checkVal("if_c4_valid", b(bus.if_valid), 32'h1);
        checkVal("if_c4_rdata", bus.if_rdata, 32'h8C08_0004);
        checkVal("if_c4_stall", b(bus.stall_fetch), 32'h0);
        checkVal("if_c4_dm_valid", b(bus.dm_valid), 32'h0);
        bus.if_req = 1'b0;
        step(); #1;
        checkVal("if_c5_valid", b(bus.if_valid), 32'h0);

        // Simultaneous requests: DM read at 0x200 first, then IF at 0x0
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200; #1;
        checkVal("sim_c0_stall_mem", b(bus.stall_mem), 32'h1);
        step(); #1;
        checkVal("sim_c1_mem_en", b(bus.mem_en), 32'h1);
        checkVal("sim_c1_addr", bus.mem_addr, 32'h200);
        step(); step(); step(); #1;
        checkVal("sim_c4_dm_valid", b(bus.dm_valid), 32'h1);
        checkVal("sim_c4_dm_rdata", bus.dm_rdata, 32'h1234_5678);
        checkVal("sim_c4_if_valid", b(bus.if_valid), 32'h0);
        checkVal("sim_c4_stall_mem", b(bus.stall_mem), 32'h0);
        checkVal("sim_c4_stall_fetch", b(bus.stall_fetch), 32'h1);
        bus.dm_req = 1'b0;
        step(); #1;
        checkVal("sim_c5_mem_en", b(bus.mem_en), 32'h0);
        checkVal("sim_c5_dm_valid", b(bus.dm_valid), 32'h0);
        step(); #1;
        checkVal("sim_c6_mem_en", b(bus.mem_en), 32'h1);
        checkVal("sim_c6_addr", bus.mem_addr, 32'h0);
        step(); step(); #1;
        checkVal("sim_c8_if_valid", b(bus.if_valid), 32'h0);
        step(); #1;
        checkVal("sim_c9_if_valid", b(bus.if_valid), 32'h1);
        checkVal("sim_c9_if_rdata", bus.if_rdata, 32'h2002_0001);
        bus.if_req = 1'b0;
        step();

        // DM write; inputs change after the grant and must not leak through
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1;
        bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF; #1;
        step();
        bus.dm_we = 1'b0; bus.dm_addr = 32'hFF0; bus.dm_wdata = 32'h0; #1;
        checkVal("wr_c1_mem_en", b(bus.mem_en), 32'h1);
        checkVal("wr_c1_mem_we", b(bus.mem_we), 32'h1);
        checkVal("wr_c1_addr", bus.mem_addr, 32'h100);
        checkVal("wr_c1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        step(); #1;
        checkVal("wr_c2_mem_en", b(bus.mem_en), 32'h0);
        checkVal("wr_c2_mem_we", b(bus.mem_we), 32'h0);
        step(); step(); #1;
        checkVal("wr_c4_dm_valid", b(bus.dm_valid), 32'h1);
        checkVal("wr_c4_dm_rdata", bus.dm_rdata, 32'h1234_5678);
        bus.dm_req = 1'b0;
        step();

        // Starvation: both requests held, record grant order
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h2000;
        nGrants = 0;
        for (int i = 0; i < 60 && nGrants < 6; i++) begin
            step(); #1;
            if (bus.mem_en === 1'b1) begin
                grants[nGrants] = bus.mem_addr;
                nGrants++;
            end
            checkVal("starve_valid_excl", b(bus.if_valid & bus.dm_valid), 32'h0);
        end
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        checkVal("starve_ngrants", 32'(nGrants), 32'd6);
        for (int k = 0; k < 6; k++) begin
            checkVal($sformatf("starve_grant%0d", k), grants[k], expGrant[k]);
        end
        for (int i = 0; i < 6; i++) step();

        // Reset in the middle of an IF access
        step(); bus.if_req = 1'b1; bus.if_addr = 32'h40; #1;
        step(); #1;
        checkVal("rmid_c1_mem_en", b(bus.mem_en), 32'h1);
        step(); reset_n = 1'b0; bus.if_req = 1'b0; #1;
        step(); reset_n = 1'b1; #1;
        checkVal("rmid_mem_en", b(bus.mem_en), 32'h0);
        checkVal("rmid_mem_addr", bus.mem_addr, 32'h0);
        checkVal("rmid_mem_wdata", bus.mem_wdata, 32'h0);
        checkVal("rmid_if_rdata", bus.if_rdata, 32'h0);
        checkVal("rmid_dm_rdata", bus.dm_rdata, 32'h0);
        checkVal("rmid_if_valid", b(bus.if_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checkVal("rmid_no_valid", b(bus.if_valid | bus.dm_valid), 32'h0);
        end
        // Fresh DM read completes with normal latency
        step(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200; #1;
        step(); step(); step(); #1;
        checkVal("rmid_new_c3_valid", b(bus.dm_valid), 32'h0);
        step(); #1;
        checkVal("rmid_new_c4_valid", b(bus.dm_valid), 32'h1);
        checkVal("rmid_new_c4_rdata", bus.dm_rdata, 32'h1234_5678);
        bus.dm_req = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 numChecks, numFails);
        $finish;
    end
endmodule
